fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//  Instruction fetch stage directly upstream of _control_unit. Holds the PC, issues
//  one read at a time to instruction memory, and presents each 32-bit instruction
//  on instr (wired to _control_unit.instruccion) with a valid/ready handshake.
//  Supports decode stall, branch redirect with flush, and halt on a HALT opcode.
// PARAMETERS
//  ADDR_W      8         PC / imem address width in words; PC wraps modulo 2**ADDR_W
//  RESET_PC    0         PC value loaded on reset
//  HALT_OP     6'b111111 opcode (instr[31:26]) that stops fetching
// PORTS
//  clk            in   1       system clock, all state on rising edge
//  rst            in   1       synchronous, active-high reset
//  imem_req       out  1       read strobe, one-cycle pulse per request
//  imem_addr      out  ADDR_W  word address of request, valid with imem_req
//  imem_rvalid    in   1       read data valid, >=1 cycle after imem_req
//  imem_rdata     in   32      instruction word, valid with imem_rvalid
//  instr          out  32      instruction to decode
//  instr_pc       out  ADDR_W  address of instr
//  instr_valid    out  1       instr/instr_pc valid
//  instr_ready    in   1       decode accepts; transfer when valid & ready
//  redirect       in   1       branch taken this cycle
//  redirect_pc    in   ADDR_W  branch target
//  halted         out  1       HALT_OP fetched; fetching stopped
// BEHAVIOUR
//  Reset: pc=RESET_PC, state=FETCH, instr=0, instr_pc=0, instr_valid=0, halted=0,
//   imem_req=0; imem_rvalid in the reset cycle is ignored.
//  FSM states FETCH, WAIT, HOLD, HALTED; at most one request outstanding.
//  FETCH: imem_req=1, imem_addr=pc (combinational) -> WAIT.
//  WAIT: on imem_rvalid: if drop flag set, clear it, -> FETCH (data discarded);
//   else if rdata[31:26]==HALT_OP -> HALTED, halted=1, instr_valid stays 0,
//   pc unchanged; else instr<=rdata, instr_pc<=pc, instr_valid<=1, pc<=pc+1 -> HOLD.
//  HOLD: instr_valid=1, instr/instr_pc stable until transfer. On instr_ready:
//   same cycle imem_req=1, imem_addr=pc; instr_valid<=0 -> WAIT.
//   Best case with 1-cycle memory: one instruction every 2 cycles.
//  HALTED: no requests; outputs hold; left only by redirect or rst.
//  Redirect (highest priority after rst, any state): pc<=redirect_pc, instr_valid<=0
//   (held instr flushed, no transfer even if instr_ready=1), halted<=0, -> FETCH.
//   If a request is outstanding and imem_rvalid is not in the same cycle, set drop
//   flag and -> WAIT instead; the stale response is discarded, then FETCH.
//   redirect coincident with imem_rvalid: response discarded, -> FETCH.
//  rvalid in FETCH/HOLD/HALTED without outstanding request: ignored.
//  pc+1 at 2**ADDR_W-1 wraps to 0; no error.
// CONFIGURATION
//  FETCH_PERF_CNT_EN defined: adds outputs fetch_cnt[15:0] (+1 per decode transfer)
//   and stall_cnt[15:0] (+1 per cycle instr_valid & !instr_ready); both reset to 0,
//   saturate at 16'hFFFF. Not defined: ports and counters absent; all other
//   behaviour identical.
// TESTING
//  1-cycle memory, mem[0..2]=A,B,C, instr_ready=1 -> instr A,B,C at pc 0,1,2, one
//   transfer every 2 cycles, imem_addr 0,1,2.
//  instr_ready=0 for 5 cycles while B held -> instr/instr_pc stable, no imem_req,
//   one transfer of B after ready rises.
//  redirect=1, redirect_pc=8'h40 while request to 3 outstanding (3-cycle memory) ->
//   response for 3 never on instr; next imem_addr=8'h40.
//  mem[5]={6'b111111,26'h0} -> halted=1 after rvalid, no further imem_req for 10
//   cycles; redirect to 0 -> halted=0, imem_addr=0.
//  ADDR_W=8, RESET_PC=8'hFF -> fetch 0xFF then imem_addr=0x00.
//  rst asserted in WAIT with rvalid same cycle -> instr_valid=0, imem_addr=RESET_PC
//   next fetch; with FETCH_PERF_CNT_EN counters read 0.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction fetch stage: holds the PC, keeps at most one instruction-memory
// read in flight and hands each fetched word to decode over a valid/ready
// handshake. It supports decode stall, branch redirect with flush, and halt
// when the HALT_OP opcode is fetched.
// Optional build macro FETCH_PERF_CNT_EN adds saturating transfer and stall
// counters as extra output ports.
module fetch_stage #(
    parameter int                ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [5:0]        HALT_OP  = 6'b111111
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_rvalid,
    input  logic [31:0]       imem_rdata,
    output logic [31:0]       instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              halted
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [15:0]       fetch_cnt,
    output logic [15:0]       stall_cnt
`endif
);

    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_WAIT   = 2'd1,
        S_HOLD   = 2'd2,
        S_HALTED = 2'd3
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_next;
    logic              drop;
    logic              drop_next;
    logic              capture;

    // The handshake outputs are decoded straight from the registered state.
    assign instr_valid = (state == S_HOLD);
    assign halted      = (state == S_HALTED);

    // Next-state logic: redirect overrides everything but reset; a redirect that
    // lands while a read is still in flight waits in S_WAIT to discard it.
    always_comb begin
        state_next = state;
        pc_next    = pc;
        drop_next  = drop;
        capture    = 1'b0;
        imem_req   = 1'b0;
        imem_addr  = pc;
        if (!rst) begin
            if (redirect) begin
                pc_next    = redirect_pc;
                state_next = S_FETCH;
                drop_next  = 1'b0;
                if (state == S_WAIT && !imem_rvalid) begin
                    state_next = S_WAIT;
                    drop_next  = 1'b1;
                end
            end else begin
                case (state)
                    S_FETCH: begin
                        imem_req   = 1'b1;
                        state_next = S_WAIT;
                    end
                    S_WAIT: begin
                        if (imem_rvalid) begin
                            if (drop) begin
                                drop_next  = 1'b0;
                                state_next = S_FETCH;
                            end else if (imem_rdata[31:26] == HALT_OP) begin
                                state_next = S_HALTED;
                            end else begin
                                capture    = 1'b1;
                                pc_next    = pc + 1'b1;
                                state_next = S_HOLD;
                            end
                        end
                    end
                    S_HOLD: begin
                        if (instr_ready) begin
                            imem_req   = 1'b1;
                            state_next = S_WAIT;
                        end
                    end
                    S_HALTED: begin
                        state_next = S_HALTED;
                    end
                    default: begin
                        state_next = S_FETCH;
                    end
                endcase
            end
        end
    end

    // State, PC, drop flag and the presented instruction register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_FETCH;
            pc       <= RESET_PC;
            drop     <= 1'b0;
            instr    <= '0;
            instr_pc <= '0;
        end else begin
            state <= state_next;
            pc    <= pc_next;
            drop  <= drop_next;
            if (capture) begin
                instr    <= imem_rdata;
                instr_pc <= pc;
            end
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic xfer_fire;
    logic stall_cycle;

    // A transfer is suppressed when a redirect flushes the held instruction.
    assign xfer_fire   = instr_valid && instr_ready && !redirect;
    assign stall_cycle = instr_valid && !instr_ready;

    // Saturating counters of decode transfers and back-pressured cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            if (xfer_fire && fetch_cnt != 16'hFFFF) begin
                fetch_cnt <= fetch_cnt + 16'd1;
            end
            if (stall_cycle && stall_cnt != 16'hFFFF) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: an ideal memory with programmable
// latency, a monitor that records requests and decode transfers, and one
// task per scenario comparing against a program-order reference model.
module tb_fetch_stage;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [7:0]  instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        redirect;
    logic [7:0]  redirect_pc;
    logic        halted;

    logic        imem_req2;
    logic [7:0]  imem_addr2;
    logic        imem_rvalid2;
    logic [31:0] imem_rdata2;
    logic [31:0] instr2;
    logic [7:0]  instr_pc2;
    logic        instr_valid2;
    logic        instr_ready2;
    logic        redirect2;
    logic [7:0]  redirect_pc2;
    logic        halted2;

`ifdef FETCH_PERF_CNT_EN
    logic [15:0] fetch_cnt;
    logic [15:0] stall_cnt;
    logic [15:0] fetch_cnt2;
    logic [15:0] stall_cnt2;
`endif

    fetch_stage #(.ADDR_W(8), .RESET_PC(8'h00), .HALT_OP(6'b111111)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .redirect(redirect), .redirect_pc(redirect_pc),
        .halted(halted)
`ifdef FETCH_PERF_CNT_EN
        , .fetch_cnt(fetch_cnt), .stall_cnt(stall_cnt)
`endif
    );

    fetch_stage #(.ADDR_W(8), .RESET_PC(8'hFF), .HALT_OP(6'b111111)) dut_ff (
        .clk(clk), .rst(rst),
        .imem_req(imem_req2), .imem_addr(imem_addr2),
        .imem_rvalid(imem_rvalid2), .imem_rdata(imem_rdata2),
        .instr(instr2), .instr_pc(instr_pc2), .instr_valid(instr_valid2),
        .instr_ready(instr_ready2), .redirect(redirect2), .redirect_pc(redirect_pc2),
        .halted(halted2)
`ifdef FETCH_PERF_CNT_EN
        , .fetch_cnt(fetch_cnt2), .stall_cnt(stall_cnt2)
`endif
    );

    logic [31:0] mem [256];
    int          mem_lat;
    int          n_cmp;
    int          n_fail;
    int          epoch;
    logic        watch3;

    logic [7:0]  req_addr [$];
    logic [7:0]  xfer_pc [$];
    logic [31:0] xfer_instr [$];
    int          xfer_cyc [$];
    logic [7:0]  req2_addr [$];
    logic [7:0]  xfer2_pc [$];
    logic [31:0] xfer2_instr [$];
    int          cyc;
    int          seen3;
    int          unstable;
    int          fetch_model;
    int          stall_model;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Ideal memory for the main DUT: answers each request after mem_lat cycles.
    initial begin
        int pend;
        logic [7:0] pend_addr;
        pend = 0;
        pend_addr = '0;
        imem_rvalid = 1'b0;
        imem_rdata = '0;
        forever begin
            @(negedge clk);
            imem_rvalid = 1'b0;
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    imem_rvalid = 1'b1;
                    imem_rdata = mem[pend_addr];
                end
            end
            if (imem_req === 1'b1) begin
                pend = mem_lat;
                pend_addr = imem_addr;
            end
        end
    end

    // Single-cycle memory for the RESET_PC=FF instance.
    initial begin
        int pend;
        logic [7:0] pend_addr;
        pend = 0;
        pend_addr = '0;
        imem_rvalid2 = 1'b0;
        imem_rdata2 = '0;
        forever begin
            @(negedge clk);
            imem_rvalid2 = 1'b0;
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    imem_rvalid2 = 1'b1;
                    imem_rdata2 = mem[pend_addr];
                end
            end
            if (imem_req2 === 1'b1) begin
                pend = 1;
                pend_addr = imem_addr2;
            end
        end
    end

    // Monitor: logs requests and transfers, tracks hold stability and counts.
    initial begin
        int seen_epoch;
        logic hold_prev;
        logic [31:0] hold_instr;
        logic [7:0] hold_pc;
        seen_epoch = 0;
        hold_prev = 1'b0;
        hold_instr = '0;
        hold_pc = '0;
        cyc = 0;
        seen3 = 0;
        unstable = 0;
        fetch_model = 0;
        stall_model = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (seen_epoch != epoch) begin
                seen_epoch = epoch;
                req_addr.delete();
                xfer_pc.delete();
                xfer_instr.delete();
                xfer_cyc.delete();
                req2_addr.delete();
                xfer2_pc.delete();
                xfer2_instr.delete();
            end
            if (rst) begin
                fetch_model = 0;
                stall_model = 0;
                hold_prev = 1'b0;
            end else begin
                if (imem_req === 1'b1) req_addr.push_back(imem_addr);
                if (imem_req2 === 1'b1) req2_addr.push_back(imem_addr2);
                if (instr_valid && instr_ready && !redirect) begin
                    xfer_pc.push_back(instr_pc);
                    xfer_instr.push_back(instr);
                    xfer_cyc.push_back(cyc);
                    fetch_model++;
                end
                if (instr_valid2 && instr_ready2) begin
                    xfer2_pc.push_back(instr_pc2);
                    xfer2_instr.push_back(instr2);
                end
                if (instr_valid && !instr_ready) stall_model++;
                if (watch3 && instr_valid && instr_pc == 8'd3) seen3++;
                if (hold_prev && instr_valid &&
                    (instr !== hold_instr || instr_pc !== hold_pc)) unstable++;
                hold_prev = instr_valid && !instr_ready && !redirect;
                hold_instr = instr;
                hold_pc = instr_pc;
            end
        end
    end

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        w = $urandom;
        if (w[31:26] == 6'b111111) w[31] = 1'b0;
        return w;
    endfunction

    task automatic fill_mem();
        for (int i = 0; i < 256; i++) mem[i] = rand_word();
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        redirect = 1'b0;
        epoch++;
        repeat (6) begin @(posedge clk); #1; end
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        instr_ready = 1'b1;
        redirect = 1'b1;
        redirect_pc = 8'h55;
        epoch++;
        repeat (3) begin @(posedge clk); #1; end
        @(negedge clk); #1;
        n_cmp++; if (imem_req !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_req got=%b exp=0", imem_req); end
        n_cmp++; if (instr_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_valid got=%b exp=0", instr_valid); end
        n_cmp++; if (halted !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_halted got=%b exp=0", halted); end
        n_cmp++; if (instr !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_instr got=%h exp=0", instr); end
        n_cmp++; if (instr_pc !== 8'h0) begin n_fail++; $display("[TB] FAIL reset_instr_pc got=%h exp=0", instr_pc); end
`ifdef FETCH_PERF_CNT_EN
        n_cmp++; if (fetch_cnt !== 16'h0) begin n_fail++; $display("[TB] FAIL reset_fetch_cnt got=%h exp=0", fetch_cnt); end
        n_cmp++; if (stall_cnt !== 16'h0) begin n_fail++; $display("[TB] FAIL reset_stall_cnt got=%h exp=0", stall_cnt); end
`endif
        @(posedge clk); #1;
        rst = 1'b0;
        redirect = 1'b0;
        @(negedge clk); #1;
        n_cmp++; if (imem_req !== 1'b1) begin n_fail++; $display("[TB] FAIL first_req got=%b exp=1", imem_req); end
        n_cmp++; if (imem_addr !== 8'h00) begin n_fail++; $display("[TB] FAIL first_addr got=%h exp=00", imem_addr); end
    endtask

    task automatic test_sequential();
        logic [31:0] exp_w [3];
        bit ok;
        exp_w[0] = 32'h1234_5678;
        exp_w[1] = 32'h0ABC_DEF0;
        exp_w[2] = 32'h2222_3333;
        for (int i = 0; i < 3; i++) mem[i] = exp_w[i];
        mem_lat = 1;
        instr_ready = 1'b1;
        do_reset();
        ok = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk); #1;
            if (xfer_pc.size() >= 3) begin ok = 1; break; end
        end
        n_cmp++;
        if (!ok) begin n_fail++; $display("[TB] FAIL seq_timeout got=%0d transfers exp=3", xfer_pc.size()); end
        else begin
            for (int k = 0; k < 3; k++) begin
                n_cmp++; if (xfer_pc[k] !== k[7:0]) begin n_fail++; $display("[TB] FAIL seq_pc[%0d] got=%h exp=%h", k, xfer_pc[k], k[7:0]); end
                n_cmp++; if (xfer_instr[k] !== exp_w[k]) begin n_fail++; $display("[TB] FAIL seq_instr[%0d] got=%h exp=%h", k, xfer_instr[k], exp_w[k]); end
                n_cmp++; if (req_addr[k] !== k[7:0]) begin n_fail++; $display("[TB] FAIL seq_addr[%0d] got=%h exp=%h", k, req_addr[k], k[7:0]); end
            end
            for (int k = 0; k < 2; k++) begin
                n_cmp++;
                if (xfer_cyc[k+1] - xfer_cyc[k] != 2) begin
                    n_fail++;
                    $display("[TB] FAIL seq_spacing[%0d] got=%0d exp=2", k, xfer_cyc[k+1] - xfer_cyc[k]);
                end
            end
        end
    endtask

    task automatic test_stall();
        bit ok;
        int r0;
        int x0;
        int u0;
        int cnt_b;
        mem_lat = 1;
        instr_ready = 1'b1;
        do_reset();
        ok = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk); #1;
            if (xfer_pc.size() >= 1) begin ok = 1; break; end
        end
        @(posedge clk); #1;
        instr_ready = 1'b0;
        if (ok) begin
            ok = 0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk); #1;
                if (instr_valid) begin ok = 1; break; end
            end
        end
        n_cmp++;
        if (!ok) begin n_fail++; $display("[TB] FAIL stall_timeout got=%b exp=valid", instr_valid); end
        else begin
            r0 = req_addr.size();
            x0 = xfer_pc.size();
            u0 = unstable;
            repeat (5) begin
                @(negedge clk); #1;
                n_cmp++; if (instr_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL stall_valid got=%b exp=1", instr_valid); end
                n_cmp++; if (instr !== mem[1]) begin n_fail++; $display("[TB] FAIL stall_instr got=%h exp=%h", instr, mem[1]); end
                n_cmp++; if (instr_pc !== 8'd1) begin n_fail++; $display("[TB] FAIL stall_pc got=%h exp=01", instr_pc); end
            end
            n_cmp++; if (req_addr.size() != r0) begin n_fail++; $display("[TB] FAIL stall_no_req got=%0d exp=%0d", req_addr.size(), r0); end
            n_cmp++; if (xfer_pc.size() != x0) begin n_fail++; $display("[TB] FAIL stall_no_xfer got=%0d exp=%0d", xfer_pc.size(), x0); end
            @(posedge clk); #1;
            instr_ready = 1'b1;
            repeat (6) begin @(negedge clk); #1; end
            cnt_b = 0;
            foreach (xfer_pc[k]) if (xfer_pc[k] == 8'd1) cnt_b++;
            n_cmp++; if (cnt_b != 1) begin n_fail++; $display("[TB] FAIL stall_b_once got=%0d exp=1", cnt_b); end
            n_cmp++;
            if (xfer_pc.size() <= x0 || xfer_instr[x0] !== mem[1]) begin
                n_fail++; $display("[TB] FAIL stall_b_xfer got=%0d transfers exp=B at %0d", xfer_pc.size(), x0);
            end
            n_cmp++; if (unstable != u0) begin n_fail++; $display("[TB] FAIL stall_stable got=%0d exp=%0d", unstable, u0); end
        end
    endtask

    task automatic test_redirect();
        bit ok;
        int x0;
        mem_lat = 3;
        instr_ready = 1'b1;
        do_reset();
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk); #1;
            if (req_addr.size() >= 4) begin ok = 1; break; end
        end
        n_cmp++;
        if (!ok) begin n_fail++; $display("[TB] FAIL redir_setup got=%0d requests exp=4", req_addr.size()); end
        else begin
            n_cmp++; if (req_addr[3] !== 8'd3) begin n_fail++; $display("[TB] FAIL redir_req3 got=%h exp=03", req_addr[3]); end
            watch3 = 1'b1;
            @(posedge clk); #1;
            redirect = 1'b1;
            redirect_pc = 8'h40;
            @(posedge clk); #1;
            redirect = 1'b0;
            x0 = xfer_pc.size();
            repeat (25) begin @(negedge clk); #1; end
            watch3 = 1'b0;
            n_cmp++; if (seen3 != 0) begin n_fail++; $display("[TB] FAIL redir_stale got=%0d exp=0", seen3); end
            n_cmp++;
            if (req_addr.size() < 5 || req_addr[4] !== 8'h40) begin
                n_fail++; $display("[TB] FAIL redir_next_addr got=%0d reqs exp=40 at index 4", req_addr.size());
            end
            n_cmp++;
            if (xfer_pc.size() <= x0 || xfer_pc[x0] !== 8'h40 || xfer_instr[x0] !== mem[8'h40]) begin
                n_fail++; $display("[TB] FAIL redir_target_xfer got=%0d transfers exp=pc 40", xfer_pc.size());
            end
        end
    endtask

    task automatic test_halt();
        bit ok;
        int r0;
        mem_lat = 1;
        instr_ready = 1'b1;
        mem[5] = {6'b111111, 26'h0};
        do_reset();
        ok = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk); #1;
            if (halted) begin ok = 1; break; end
        end
        n_cmp++;
        if (!ok) begin n_fail++; $display("[TB] FAIL halt_timeout got=%b exp=1", halted); end
        else begin
            n_cmp++; if (instr_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL halt_valid got=%b exp=0", instr_valid); end
            n_cmp++;
            if (xfer_pc.size() != 5 || xfer_pc[4] !== 8'd4) begin
                n_fail++; $display("[TB] FAIL halt_xfers got=%0d exp=5 ending at pc 4", xfer_pc.size());
            end
            r0 = req_addr.size();
            repeat (10) begin @(negedge clk); #1; end
            n_cmp++; if (req_addr.size() != r0) begin n_fail++; $display("[TB] FAIL halt_no_req got=%0d exp=%0d", req_addr.size(), r0); end
            n_cmp++; if (halted !== 1'b1) begin n_fail++; $display("[TB] FAIL halt_sticky got=%b exp=1", halted); end
            @(posedge clk); #1;
            redirect = 1'b1;
            redirect_pc = 8'h00;
            @(posedge clk); #1;
            redirect = 1'b0;
            @(negedge clk); #1;
            n_cmp++; if (halted !== 1'b0) begin n_fail++; $display("[TB] FAIL unhalt got=%b exp=0", halted); end
            n_cmp++; if (imem_req !== 1'b1) begin n_fail++; $display("[TB] FAIL unhalt_req got=%b exp=1", imem_req); end
            n_cmp++; if (imem_addr !== 8'h00) begin n_fail++; $display("[TB] FAIL unhalt_addr got=%h exp=00", imem_addr); end
        end
        mem[5] = rand_word();
    endtask

    task automatic test_wrap();
        int x0;
        mem_lat = 1;
        instr_ready = 1'b1;
        do_reset();
        repeat (8) begin @(negedge clk); #1; end
        n_cmp++;
        if (req2_addr.size() < 2 || xfer2_pc.size() < 1) begin
            n_fail++; $display("[TB] FAIL wrap_ff_timeout got=%0d reqs exp=2", req2_addr.size());
        end else begin
            n_cmp++; if (req2_addr[0] !== 8'hFF) begin n_fail++; $display("[TB] FAIL wrap_ff_addr0 got=%h exp=ff", req2_addr[0]); end
            n_cmp++; if (req2_addr[1] !== 8'h00) begin n_fail++; $display("[TB] FAIL wrap_ff_addr1 got=%h exp=00", req2_addr[1]); end
            n_cmp++; if (xfer2_pc[0] !== 8'hFF) begin n_fail++; $display("[TB] FAIL wrap_ff_pc got=%h exp=ff", xfer2_pc[0]); end
            n_cmp++; if (xfer2_instr[0] !== mem[8'hFF]) begin n_fail++; $display("[TB] FAIL wrap_ff_instr got=%h exp=%h", xfer2_instr[0], mem[8'hFF]); end
        end
        @(posedge clk); #1;
        redirect = 1'b1;
        redirect_pc = 8'hFF;
        @(posedge clk); #1;
        redirect = 1'b0;
        x0 = xfer_pc.size();
        repeat (12) begin @(negedge clk); #1; end
        n_cmp++;
        if (xfer_pc.size() < x0 + 2 || xfer_pc[x0] !== 8'hFF || xfer_pc[x0+1] !== 8'h00) begin
            n_fail++; $display("[TB] FAIL wrap_redirect got=%0d transfers exp=pc ff then 00", xfer_pc.size() - x0);
        end
    endtask

    task automatic test_rst_in_wait();
        bit ok;
        mem_lat = 1;
        instr_ready = 1'b1;
        do_reset();
        ok = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk); #1;
            if (req_addr.size() >= 3) begin ok = 1; break; end
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk); #1;
        n_cmp++; if (!ok) begin n_fail++; $display("[TB] FAIL rstwait_setup got=%0d reqs exp=3", req_addr.size()); end
        n_cmp++; if (instr_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL rstwait_valid got=%b exp=0", instr_valid); end
        n_cmp++; if (imem_req !== 1'b1) begin n_fail++; $display("[TB] FAIL rstwait_req got=%b exp=1", imem_req); end
        n_cmp++; if (imem_addr !== 8'h00) begin n_fail++; $display("[TB] FAIL rstwait_addr got=%h exp=00", imem_addr); end
        n_cmp++; if (instr !== 32'h0) begin n_fail++; $display("[TB] FAIL rstwait_instr got=%h exp=0", instr); end
`ifdef FETCH_PERF_CNT_EN
        n_cmp++; if (fetch_cnt !== 16'h0) begin n_fail++; $display("[TB] FAIL rstwait_fetch_cnt got=%h exp=0", fetch_cnt); end
        n_cmp++; if (stall_cnt !== 16'h0) begin n_fail++; $display("[TB] FAIL rstwait_stall_cnt got=%h exp=0", stall_cnt); end
`endif
    endtask

    // Reference model: between redirects decode must see consecutive PCs, each
    // carrying the memory word at that PC, starting at the redirect target.
    task automatic test_random();
        logic [7:0] exp_pc;
        logic [7:0] tgt;
        bit redir;
        int xi;
        int u0;
        for (int it = 0; it < 4; it++) begin
            fill_mem();
            mem_lat = $urandom_range(1, 4);
            instr_ready = 1'b1;
            do_reset();
            exp_pc = 8'h00;
            xi = 0;
            u0 = unstable;
            for (int c = 0; c < 300; c++) begin
                @(posedge clk); #1;
                instr_ready = ($urandom_range(0, 3) != 0);
                redir = ($urandom_range(0, 19) == 0);
                tgt = 8'($urandom);
                redirect = redir;
                redirect_pc = tgt;
                @(negedge clk); #1;
                while (xi < xfer_pc.size()) begin
                    n_cmp++;
                    if (xfer_pc[xi] !== exp_pc || xfer_instr[xi] !== mem[exp_pc]) begin
                        n_fail++;
                        $display("[TB] FAIL rand_xfer it=%0d got pc=%h instr=%h exp pc=%h instr=%h",
                                 it, xfer_pc[xi], xfer_instr[xi], exp_pc, mem[exp_pc]);
                    end
                    exp_pc = exp_pc + 8'd1;
                    xi++;
                end
                if (redir) exp_pc = tgt;
            end
            @(posedge clk); #1;
            redirect = 1'b0;
            n_cmp++; if (xi < 10) begin n_fail++; $display("[TB] FAIL rand_progress it=%0d got=%0d exp>=10", it, xi); end
            n_cmp++; if (unstable != u0) begin n_fail++; $display("[TB] FAIL rand_stable it=%0d got=%0d exp=%0d", it, unstable, u0); end
`ifdef FETCH_PERF_CNT_EN
            n_cmp++; if (fetch_cnt !== 16'(fetch_model)) begin n_fail++; $display("[TB] FAIL rand_fetch_cnt got=%0d exp=%0d", fetch_cnt, fetch_model); end
            n_cmp++; if (stall_cnt !== 16'(stall_model)) begin n_fail++; $display("[TB] FAIL rand_stall_cnt got=%0d exp=%0d", stall_cnt, stall_model); end
`endif
        end
    endtask

    // Scenario sequence followed by the one-line summary.
    initial begin
        rst = 1'b1;
        instr_ready = 1'b0;
        redirect = 1'b0;
        redirect_pc = '0;
        instr_ready2 = 1'b1;
        redirect2 = 1'b0;
        redirect_pc2 = '0;
        watch3 = 1'b0;
        mem_lat = 1;
        epoch = 0;
        n_cmp = 0;
        n_fail = 0;
        fill_mem();
        test_reset();
        test_sequential();
        test_stall();
        test_redirect();
        test_halt();
        test_wrap();
        test_rst_in_wait();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
